// File: rtl/iob_axi_single_master.sv
// Native iob request port to single-beat AXI4 master bridge.
// At most one transaction in flight. 32-bit native data is placed in, and taken from, one lane of the wider AXI bus.
module iob_axi_single_master #(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int AXI_DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    valid,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [31:0]             wdata,
    input  logic [3:0]              wstrb,
    output logic [31:0]             rdata,
    output logic                    ready,
    output logic                    err,

    output logic [ADDR_W-1:0]       m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [AXI_DATA_W-1:0]   m_axi_wdata,
    output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_W-1:0]       m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [AXI_DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int STRB_W = AXI_DATA_W / 8;
    localparam int NLANES = AXI_DATA_W / 32;
    localparam int L      = $clog2(STRB_W);
    localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;

    typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t state, state_nxt;

    logic [LANE_W-1:0]             lane_in, lane_r;
    logic [ADDR_W-3:0]             word_r;
    logic [31:0]                   wdata_r;
    logic [NLANES-1:0][3:0]        strb_lanes;
    logic [NLANES-1:0][31:0]       rdata_lanes;
    logic                          accept;
    logic                          aw_done, w_done;
    logic                          unused_addr_lsb;

    generate
        if (NLANES > 1) begin : g_lane
            assign lane_in = addr[L-1:2];
        end else begin : g_lane0
            assign lane_in = '0;
        end
    endgenerate

    assign unused_addr_lsb = ^addr[1:0];

    // Held valid is ignored during the ready pulse so it is not taken twice.
    assign accept  = (state == IDLE) && valid && !ready;
    assign aw_done = !m_axi_awvalid || m_axi_awready;
    assign w_done  = !m_axi_wvalid  || m_axi_wready;

    assign m_axi_awaddr  = {word_r, 2'b00};
    assign m_axi_araddr  = {word_r, 2'b00};
    assign m_axi_wdata   = {NLANES{wdata_r}};
    assign m_axi_arvalid = (state == RD_ADDR);
    assign m_axi_bready  = (state == WR_RESP);
    assign m_axi_rready  = (state == RD_DATA);
    assign rdata_lanes   = m_axi_rdata;

    always_comb begin
        strb_lanes          = '0;
        strb_lanes[lane_in] = wstrb;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (wstrb != 4'b0) ? WRITE : RD_ADDR;
            WRITE:   if (aw_done && w_done) state_nxt = WR_RESP;
            WR_RESP: if (m_axi_bvalid) state_nxt = IDLE;
            RD_ADDR: if (m_axi_arready) state_nxt = RD_DATA;
            RD_DATA: if (m_axi_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wstrb   <= '0;
            word_r        <= '0;
            wdata_r       <= '0;
            lane_r        <= '0;
            ready         <= 1'b0;
            err           <= 1'b0;
            rdata         <= '0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    word_r      <= addr[ADDR_W-1:2];
                    wdata_r     <= wdata;
                    m_axi_wstrb <= strb_lanes;
                    lane_r      <= lane_in;
                    if (wstrb != 4'b0) begin
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                    end
                end
                // AW and W retire independently, in either order.
                WRITE: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                end
                WR_RESP: if (m_axi_bvalid) begin
                    ready <= 1'b1;
                    err   <= (m_axi_bresp != 2'b00);
                end
                RD_DATA: if (m_axi_rvalid) begin
                    ready <= 1'b1;
                    err   <= (m_axi_rresp != 2'b00);
                    rdata <= rdata_lanes[lane_r];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_axi_single_master.sv
// Bench for iob_axi_single_master at AXI_DATA_W=256 with a reactive AXI slave, a word-level memory model,
// and a per-cycle checker.
module tb_iob_axi_single_master;

    localparam int ADDR_W = 30;
    localparam int AXW    = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic [31:0]       rdata;
    logic              ready, err;
    logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
    logic              m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [AXW-1:0]    m_axi_wdata, m_axi_rdata;
    logic [AXW/8-1:0]  m_axi_wstrb;
    logic [1:0]        m_axi_bresp, m_axi_rresp;
    logic              m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic              m_axi_rvalid, m_axi_rready;

    iob_axi_single_master #(.ADDR_W(ADDR_W), .DATA_W(32), .AXI_DATA_W(AXW)) dut (
        .clk(clk), .rst(rst),
        .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .ready(ready), .err(err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int unsigned a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // ---------------- reactive slave ----------------
    int aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0] r_resp_force = 2'b00;
    bit aw_hs, w_hs, ar_hs, b_hs, r_hs, have_aw, have_w, have_ar;
    int aw_wait, w_wait, ar_wait, r_wait;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic [ADDR_W-1:0] s_awaddr, s_araddr;
    logic [AXW-1:0]    s_wdata;
    logic [AXW/8-1:0]  s_wstrb;
    logic [7:0]        smem [int unsigned];

    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
        m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = '0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
                {aw_hs, w_hs, ar_hs, b_hs, r_hs, have_aw, have_w, have_ar} = '0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
            end else begin
                if (aw_hs) begin have_aw = 1; aw_cnt++; aw_wait = 0; end
                if (w_hs)  begin have_w = 1;  w_cnt++;  w_wait = 0;  end
                if (ar_hs) begin have_ar = 1; ar_cnt++; ar_wait = 0; end
                if (b_hs)  begin m_axi_bvalid = 0; have_aw = 0; have_w = 0; b_cnt++; end
                if (r_hs)  begin m_axi_rvalid = 0; have_ar = 0; r_wait = 0; r_cnt++; end
                m_axi_awready = 0;
                if (m_axi_awvalid && !have_aw) begin
                    if (aw_wait >= aw_delay) begin m_axi_awready = 1; s_awaddr = m_axi_awaddr; end
                    else aw_wait++;
                end
                aw_hs = m_axi_awvalid && m_axi_awready;
                m_axi_wready = 0;
                if (m_axi_wvalid && !have_w) begin
                    if (w_wait >= w_delay) begin m_axi_wready = 1; s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb; end
                    else w_wait++;
                end
                w_hs = m_axi_wvalid && m_axi_wready;
                if (have_aw && have_w && !m_axi_bvalid) begin
                    for (int i = 0; i < AXW/8; i++)
                        if (s_wstrb[i]) smem[(int'(s_awaddr) & ~(AXW/8-1)) + i] = s_wdata[8*i +: 8];
                    m_axi_bvalid = 1; m_axi_bresp = 2'b00;
                end
                b_hs = m_axi_bvalid && m_axi_bready;
                m_axi_arready = 0;
                if (m_axi_arvalid && !have_ar) begin
                    if (ar_wait >= ar_delay) begin m_axi_arready = 1; s_araddr = m_axi_araddr; end
                    else ar_wait++;
                end
                ar_hs = m_axi_arvalid && m_axi_arready;
                if (have_ar && !m_axi_rvalid) begin
                    if (r_wait >= r_delay) begin
                        for (int i = 0; i < AXW/8; i++) begin
                            int unsigned ba;
                            ba = (int'(s_araddr) & ~(AXW/8-1)) + i;
                            m_axi_rdata[8*i +: 8] = smem.exists(ba) ? smem[ba] : pat(ba);
                        end
                        m_axi_rvalid = 1; m_axi_rresp = r_resp_force;
                    end else r_wait++;
                end
                r_hs = m_axi_rvalid && m_axi_rready;
            end
        end
    end

    // ---------------- behavioural model ----------------
    logic [31:0] mmem [int unsigned];
    bit          exp_active = 0, exp_rd = 0, exp_err = 0, last_err = 0, prev_ready = 0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [31:0] exp_strb = '0, exp_rdata = '0, last_rdata = '0;
    logic [AXW-1:0] exp_wdata = '0;

    function automatic logic [31:0] rd_model(input int unsigned wa);
        if (mmem.exists(wa)) return mmem[wa];
        return {pat(wa + 3), pat(wa + 2), pat(wa + 1), pat(wa)};
    endfunction

    // Per-cycle checker
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                if (ready) begin
                    chk("ready_expected", exp_active, 1'b1);
                    chk("ready_single_pulse", prev_ready, 1'b0);
                    if (exp_active) begin
                        chk("err", err, exp_err);
                        if (exp_rd) begin
                            chk("rdata", rdata, exp_rdata);
                            last_rdata = exp_rdata;
                        end
                        exp_active = 0;
                    end
                end else begin
                    chk("rdata_hold", rdata, last_rdata);
                    chk("err_without_ready", err, 1'b0);
                end
                if (m_axi_awvalid) begin
                    chk("awvalid_context", exp_active && !exp_rd, 1'b1);
                    chk("awaddr", m_axi_awaddr, exp_addr);
                end
                if (m_axi_wvalid) begin
                    chk("wvalid_context", exp_active && !exp_rd, 1'b1);
                    chk("wstrb", m_axi_wstrb, exp_strb);
                    chk("wdata", m_axi_wdata, exp_wdata);
                end
                if (m_axi_arvalid) begin
                    chk("arvalid_context", exp_active && exp_rd, 1'b1);
                    chk("araddr", m_axi_araddr, exp_addr);
                end
                if (have_aw) chk("awvalid_dropped", m_axi_awvalid, 1'b0);
                if (have_w)  chk("wvalid_dropped", m_axi_wvalid, 1'b0);
            end
            prev_ready = ready;
        end
    end

    task automatic do_req(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit hold, input bit scramble);
        int unsigned wa, lane;
        logic [31:0] w;
        bit got;
        int aw0, w0, b0, ar0, r0;
        wa   = int'(a) & ~3;
        lane = (int'(a) % (AXW/8)) / 4;
        @(negedge clk);
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
        exp_rd    = (s == 4'b0);
        exp_addr  = ADDR_W'(wa);
        exp_strb  = 32'(s) << (4 * lane);
        exp_wdata = {(AXW/32){d}};
        exp_err   = 0;
        if (exp_rd) begin
            exp_rdata = rd_model(wa);
            exp_err   = (r_resp_force != 2'b00);
        end else begin
            w = rd_model(wa);
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            mmem[wa] = w;
        end
        exp_active = 1;
        valid = 1; addr = a; wdata = d; wstrb = s;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            if (ready) begin got = 1; last_err = err; end
            else if (scramble && i == 1) begin addr = ~a; wdata = ~d; end
        end
        chk("request_completes", got, 1'b1);
        if (hold) begin @(posedge clk); #1; end
        valid = 0;
        repeat (hold ? 3 : 1) @(posedge clk);
        #1;
        chk("aw_count", aw_cnt - aw0, exp_rd ? 0 : 1);
        chk("w_count",  w_cnt - w0,   exp_rd ? 0 : 1);
        chk("b_count",  b_cnt - b0,   exp_rd ? 0 : 1);
        chk("ar_count", ar_cnt - ar0, exp_rd ? 1 : 0);
        chk("r_count",  r_cnt - r0,   exp_rd ? 1 : 0);
    endtask

    initial begin
        bit got;
        rst = 0; valid = 0; addr = '0; wdata = '0; wstrb = '0;
        #3;
        chk("rst_ready", ready, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
        chk("rst_bready_rready", {m_axi_bready, m_axi_rready}, 2'b00);
        repeat (2) @(negedge clk);
        rst = 1;

        // basic write/read at lane 0
        do_req(30'h100, 32'hDEADBEEF, 4'hF, 0, 0);
        chk("lit_awaddr_100", s_awaddr, 30'h100);
        chk("lit_wstrb_100", s_wstrb, 32'h0000_000F);
        chk("lit_werr_100", last_err, 1'b0);
        do_req(30'h100, 32'h0, 4'h0, 0, 0);
        chk("lit_rdata_100", rdata, 32'hDEADBEEF);

        // lane 7 placement and extraction
        do_req(30'h1C, 32'h0000A5A5, 4'h3, 0, 0);
        chk("lit_wstrb_lane7", s_wstrb, 32'h3000_0000);
        chk("lit_wdata_lane7", s_wdata[255:224], 32'h0000A5A5);
        do_req(30'h1C, 32'h0, 4'h0, 0, 0);
        chk("lit_rdata_1c_lo", rdata[15:0], 16'hA5A5);

        // independent AW/W handshakes in both orders and together
        aw_delay = 5; w_delay = 0;
        do_req(30'h200, 32'h11111111, 4'hF, 0, 0);
        aw_delay = 0; w_delay = 5;
        do_req(30'h204, 32'h22222222, 4'hC, 0, 0);
        aw_delay = 2; w_delay = 2;
        do_req(30'h208, 32'h33333333, 4'h6, 0, 1);
        aw_delay = 0; w_delay = 0;
        do_req(30'h204, 32'h0, 4'h0, 0, 0);
        ar_delay = 3;
        do_req(30'h208, 32'h0, 4'h0, 0, 1);
        ar_delay = 0;

        // error response then a clean read
        r_resp_force = 2'b10;
        do_req(30'h40, 32'h0, 4'h0, 0, 0);
        chk("lit_rerr_40", last_err, 1'b1);
        r_resp_force = 2'b00;
        do_req(30'h40, 32'h0, 4'h0, 0, 0);
        chk("lit_rok_40", last_err, 1'b0);

        // valid held through the ready cycle
        do_req(30'h300, 32'hCAFEF00D, 4'hF, 1, 0);
        do_req(30'h300, 32'h0, 4'h0, 1, 0);
        chk("lit_rdata_300", rdata, 32'hCAFEF00D);

        // reset while waiting in RD_DATA
        r_delay = 30;
        @(negedge clk);
        exp_rd = 1; exp_addr = 30'h80; exp_rdata = rd_model(32'h80); exp_err = 0; exp_active = 1;
        valid = 1; addr = 30'h80; wstrb = 4'h0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            if (m_axi_rready) got = 1;
        end
        chk("reach_rd_data", got, 1'b1);
        #2;
        rst = 0; valid = 0; exp_active = 0; last_rdata = '0;
        #1;
        chk("mid_rst_arvalid", m_axi_arvalid, 1'b0);
        chk("mid_rst_rready", m_axi_rready, 1'b0);
        chk("mid_rst_ready", ready, 1'b0);
        chk("mid_rst_rdata", rdata, 32'h0);
        repeat (2) @(negedge clk);
        r_delay = 0;
        rst = 1;
        do_req(30'h100, 32'h0, 4'h0, 0, 0);
        chk("lit_post_rst_read", rdata, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
